// File: rtl/i2s_tx_frame_scheduler.sv
// I2S transmit frame scheduler: captures L/R samples over AXI-Stream, divides aud_mclk into SCLK/LRCLK
// and serialises standard I2S frames MSB-first. Define I2S_TX_UNDERFLOW_CNT_EN to add underflow_cnt.
module i2s_tx_frame_scheduler #(
  parameter int AUD_WIDTH  = 24,
  parameter int DATA_WIDTH = 32,
  parameter int TID_WIDTH  = 3,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  aud_mclk,
  input  logic                  aud_mrst,
  input  logic                  ctrl_en,
  input  logic [DIV_WIDTH-1:0]  sclk_div,
  input  logic                  irq_clr,
  input  logic [DATA_WIDTH-1:0] s_axis_aud_tdata,
  input  logic [TID_WIDTH-1:0]  s_axis_aud_tid,
  input  logic                  s_axis_aud_tvalid,
  output logic                  s_axis_aud_tready,
  output logic                  sclk_out,
  output logic                  lrclk_out,
  output logic                  sdata_out,
  output logic                  busy,
  output logic                  underflow,
`ifdef I2S_TX_UNDERFLOW_CNT_EN
  output logic                  chan_err,
  output logic [15:0]           underflow_cnt
`else
  output logic                  chan_err
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_FILL, RUN} state_t;

  state_t                 state, state_nx;
  logic [AUD_WIDTH-1:0]   slot_l, slot_r;
  logic [1:0]             slot_full, slot_full_nx;
  logic                   exp_ch;
  logic [DIV_WIDTH-1:0]   div_cnt, d_cur, d_new;
  logic [5:0]             bit_cnt, bit_nx;
  logic [63:0]            frame, pair_vec, frame_nx;
  logic                   both_full, accept, tid_ok, take;
  logic                   tick, wrap, reload, enter_run, go_idle;
  logic                   uf_set, ce_set;
  logic                   unused_hi;

  assign unused_hi = ^s_axis_aud_tdata[DATA_WIDTH-1:AUD_WIDTH];

  assign both_full         = &slot_full;
  assign s_axis_aud_tready = (state != IDLE) && !slot_full[exp_ch];
  assign busy              = (state != IDLE);
  assign accept            = s_axis_aud_tvalid && s_axis_aud_tready;
  assign tid_ok            = (s_axis_aud_tid == TID_WIDTH'(exp_ch));
  assign take              = accept && tid_ok;

  // Each half-frame is a 0 delay bit, the sample MSB-first, then zero padding to 32 bits.
  assign pair_vec = {32'(slot_l) << (31 - AUD_WIDTH), 32'(slot_r) << (31 - AUD_WIDTH)};
  assign frame_nx = both_full ? pair_vec : 64'd0;

  assign d_new  = (sclk_div == '0) ? DIV_WIDTH'(1) : sclk_div;
  assign tick   = (state == RUN) && (div_cnt == d_cur - DIV_WIDTH'(1));
  assign bit_nx = bit_cnt + 6'd1;
  assign wrap   = tick && sclk_out && (bit_cnt == 6'd63);
  assign reload = wrap && ctrl_en;
  assign uf_set = reload && !both_full;
  assign ce_set = accept && !tid_ok;

  always_ff @(posedge aud_mclk) begin
    if (aud_mrst) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    enter_run = 1'b0;
    go_idle   = 1'b0;
    case (state)
      IDLE:      if (ctrl_en) state_nx = WAIT_FILL;
      WAIT_FILL: begin
        if (!ctrl_en) begin
          state_nx = IDLE;
          go_idle  = 1'b1;
        end else if (both_full) begin
          state_nx  = RUN;
          enter_run = 1'b1;
        end
      end
      RUN: begin
        // A stop request only takes effect at the frame boundary, so re-enabling before it cancels.
        if (wrap && !ctrl_en) begin
          state_nx = IDLE;
          go_idle  = 1'b1;
        end
      end
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    slot_full_nx = slot_full;
    if (enter_run || (reload && both_full)) slot_full_nx = 2'b00;
    if (take) slot_full_nx[exp_ch] = 1'b1;
    if (go_idle) slot_full_nx = 2'b00;
  end

  always_ff @(posedge aud_mclk) begin
    if (aud_mrst) begin
      slot_full <= 2'b00;
      exp_ch    <= 1'b0;
      slot_l    <= '0;
      slot_r    <= '0;
    end else begin
      slot_full <= slot_full_nx;
      if (go_idle)   exp_ch <= 1'b0;
      else if (take) exp_ch <= ~exp_ch;
      if (take && !exp_ch) slot_l <= s_axis_aud_tdata[AUD_WIDTH-1:0];
      if (take &&  exp_ch) slot_r <= s_axis_aud_tdata[AUD_WIDTH-1:0];
    end
  end

  always_ff @(posedge aud_mclk) begin
    if (aud_mrst) begin
      div_cnt   <= '0;
      d_cur     <= DIV_WIDTH'(1);
      sclk_out  <= 1'b0;
      bit_cnt   <= 6'd0;
      lrclk_out <= 1'b0;
      sdata_out <= 1'b0;
      frame     <= 64'd0;
    end else if (state != RUN || go_idle) begin
      div_cnt   <= '0;
      sclk_out  <= 1'b0;
      bit_cnt   <= 6'd0;
      lrclk_out <= 1'b0;
      sdata_out <= 1'b0;
      if (enter_run) begin
        frame <= pair_vec;
        d_cur <= d_new;
      end
    end else if (tick) begin
      div_cnt  <= '0;
      d_cur    <= d_new;
      sclk_out <= ~sclk_out;
      // Data and word select change only on the SCLK falling toggle.
      if (sclk_out) begin
        bit_cnt   <= bit_nx;
        lrclk_out <= bit_nx[5];
        if (wrap) begin
          frame     <= frame_nx;
          sdata_out <= frame_nx[63];
        end else begin
          sdata_out <= frame[~bit_nx];
        end
      end
    end else begin
      div_cnt <= div_cnt + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge aud_mclk) begin
    if (aud_mrst) begin
      underflow <= 1'b0;
      chan_err  <= 1'b0;
    end else begin
      underflow <= uf_set | (underflow & ~irq_clr);
      chan_err  <= ce_set | (chan_err & ~irq_clr);
    end
  end

`ifdef I2S_TX_UNDERFLOW_CNT_EN
  always_ff @(posedge aud_mclk) begin
    if (aud_mrst)
      underflow_cnt <= 16'd0;
    else if (uf_set)
      underflow_cnt <= irq_clr ? 16'd1 :
                       (underflow_cnt == 16'hFFFF) ? underflow_cnt : underflow_cnt + 16'd1;
    else if (irq_clr)
      underflow_cnt <= 16'd0;
  end
`endif

endmodule
